// File: rtl/xgmii_frame_generator.sv
// XGMII test-frame generator.
// Emits bursts of Ethernet-like frames on an XGMII-style data/control bus:
// start word (0xFB + preamble + SFD), an incrementing-byte payload, a
// terminate character (0xFD), then idle (0x07) inter-packet gap words.
// The state register always names the word that will be presented on the
// next rising edge, so every output is a plain register loaded from a small
// combinational word selector.
module xgmii_frame_generator #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_gen,
  input  logic                    stop_gen,
  input  logic [15:0]             frame_len,
  input  logic [7:0]              num_frames,
  input  logic [3:0]              ipg_cycles,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [DATA_WIDTH/8-1:0] ctrl_out,
  output logic                    busy,
  output logic                    frame_done,
  output logic [15:0]             frames_sent,
  output logic [31:0]             data_char_count,
  output logic [31:0]             ctrl_char_count
);

  localparam int L  = DATA_WIDTH / 8;
  localparam int LW = $clog2(L + 1);

  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_PRE   = 8'h55;
  localparam logic [7:0] XG_SFD   = 8'hD5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PAYLOAD,
    TERM,
    IPG
  } state_t;

  state_t state_reg;

  // Burst parameters captured when a burst starts.
  logic [15:0] frame_len_reg;
  logic [7:0]  num_frames_reg;
  logic [3:0]  ipg_reg;

  // Progress through the burst / current frame.
  logic [7:0]  frames_left_reg;
  logic [3:0]  ipg_cnt_reg;
  logic [15:0] byte_idx_reg;
  logic        stop_seen_reg;

  // Candidate words for each state.
  logic [DATA_WIDTH-1:0] idle_data;
  logic [DATA_WIDTH-1:0] start_data;
  logic [DATA_WIDTH-1:0] term_data;
  logic [DATA_WIDTH-1:0] pay_data;
  logic [L-1:0]          start_ctrl;
  logic [L-1:0]          term_ctrl;
  logic [L-1:0]          pay_ctrl;

  // Word about to be presented and its control-lane population.
  logic [DATA_WIDTH-1:0] word_data;
  logic [L-1:0]          word_ctrl;
  logic [LW-1:0]         ctrl_ones;

  logic [16:0] len_ext;
  logic        last_word;
  logic        len_aligned;
  logic        term_now;
  logic        burst_over;
  logic [3:0]  ipg_load;

  assign len_ext     = {1'b0, frame_len_reg};
  // The current payload word reaches (or passes) the end of the frame.
  assign last_word   = ({1'b0, byte_idx_reg} + 17'(L)) >= len_ext;
  // Payload fills whole words, so the terminate needs a word of its own.
  assign len_aligned = (frame_len_reg % 16'(L)) == 16'd0;
  // The word being presented carries the terminate character.
  assign term_now    = (state_reg == TERM) ||
                       ((state_reg == PAYLOAD) && last_word && !len_aligned);
  // At the end of the gap: stop requested (possibly this very cycle) or
  // the counted burst is exhausted.
  assign burst_over  = stop_seen_reg || stop_gen ||
                       ((num_frames_reg != 8'd0) && (frames_left_reg == 8'd0));
  // A zero gap setting still yields one idle word between frames.
  assign ipg_load    = (ipg_reg == 4'd0) ? 4'd1 : ipg_reg;

  // Per-lane construction of the fixed words and the payload word.
  generate
    for (genvar gi = 0; gi < L; gi++) begin : g_lane
      logic [16:0] idx;
      assign idx = {1'b0, byte_idx_reg} + 17'(gi);

      assign idle_data[8*gi +: 8]  = XG_IDLE;
      assign start_data[8*gi +: 8] = (gi == 0)     ? XG_START :
                                     (gi == L - 1) ? XG_SFD : XG_PRE;
      assign start_ctrl[gi]        = (gi == 0);
      assign term_data[8*gi +: 8]  = (gi == 0) ? XG_TERM : XG_IDLE;
      assign term_ctrl[gi]         = 1'b1;
      // Payload byte = index within frame; first lane past the end holds
      // the terminate, the remainder are idles.
      assign pay_data[8*gi +: 8]   = (idx < len_ext)  ? idx[7:0] :
                                     (idx == len_ext) ? XG_TERM : XG_IDLE;
      assign pay_ctrl[gi]          = (idx >= len_ext);
    end
  endgenerate

  function automatic logic [LW-1:0] count_ones(input logic [L-1:0] v);
    logic [LW-1:0] n;
    n = '0;
    for (int i = 0; i < L; i++) begin
      n = n + LW'(v[i]);
    end
    return n;
  endfunction

  // Select the word the current state will present on the next edge.
  always_comb begin
    word_data = idle_data;
    word_ctrl = '1;
    case (state_reg)
      START:   begin word_data = start_data; word_ctrl = start_ctrl; end
      PAYLOAD: begin word_data = pay_data;   word_ctrl = pay_ctrl;   end
      TERM:    begin word_data = term_data;  word_ctrl = term_ctrl;  end
      default: begin word_data = idle_data;  word_ctrl = '1;         end
    endcase
  end

  assign ctrl_ones = count_ones(word_ctrl);

  // Burst FSM with registered bus outputs, status and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      frame_len_reg   <= '0;
      num_frames_reg  <= '0;
      ipg_reg         <= '0;
      frames_left_reg <= '0;
      ipg_cnt_reg     <= '0;
      byte_idx_reg    <= '0;
      stop_seen_reg   <= 1'b0;
      data_out        <= idle_data;
      ctrl_out        <= '1;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      frames_sent     <= '0;
      data_char_count <= '0;
      ctrl_char_count <= '0;
    end else begin
      data_out   <= word_data;
      ctrl_out   <= word_ctrl;
      frame_done <= term_now;
      busy       <= (state_reg != IDLE);

      if (term_now) begin
        if (frames_sent != 16'hFFFF) begin
          frames_sent <= frames_sent + 16'd1;
        end
        if (frames_left_reg != 8'd0) begin
          frames_left_reg <= frames_left_reg - 8'd1;
        end
      end

      // Only words presented during a burst are counted.
      if (state_reg != IDLE) begin
        data_char_count <= data_char_count + 32'(L) - 32'(ctrl_ones);
        ctrl_char_count <= ctrl_char_count + 32'(ctrl_ones);
        if (stop_gen) begin
          stop_seen_reg <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          stop_seen_reg <= 1'b0;
          if (start_gen) begin
            frame_len_reg   <= frame_len;
            num_frames_reg  <= num_frames;
            ipg_reg         <= ipg_cycles;
            frames_left_reg <= num_frames;
            state_reg       <= START;
          end
        end
        START: begin
          byte_idx_reg <= '0;
          state_reg    <= (frame_len_reg == 16'd0) ? TERM : PAYLOAD;
        end
        PAYLOAD: begin
          byte_idx_reg <= byte_idx_reg + 16'(L);
          if (last_word) begin
            if (len_aligned) begin
              state_reg <= TERM;
            end else begin
              ipg_cnt_reg <= ipg_load;
              state_reg   <= IPG;
            end
          end
        end
        TERM: begin
          ipg_cnt_reg <= ipg_load;
          state_reg   <= IPG;
        end
        IPG: begin
          if (ipg_cnt_reg <= 4'd1) begin
            if (burst_over) begin
              stop_seen_reg <= 1'b0;
              state_reg     <= IDLE;
            end else begin
              state_reg <= START;
            end
          end else begin
            ipg_cnt_reg <= ipg_cnt_reg - 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
